// File: rtl/a2d_share_arb.sv
// rtl/a2d_share_arb.sv - two-port arbiter sharing one A2D converter
// Port 0 normally wins ties; a starvation count forces port 1 through after STARVE_LIM losses.
module a2d_share_arb #(
  parameter int STARVE_LIM = 4,
  parameter int TMO_CYC    = 4095
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_strt,
  input  logic [2:0]  req0_chnnl,
  output logic        req0_cmplt,
  output logic [11:0] req0_res,
  input  logic        req1_strt,
  input  logic [2:0]  req1_chnnl,
  output logic        req1_cmplt,
  output logic [11:0] req1_res,
  output logic        a2d_strt_cnv,
  output logic [2:0]  a2d_chnnl,
  input  logic        a2d_cnv_cmplt,
  input  logic [11:0] a2d_res,
  output logic        busy,
  output logic        ovr_err,
  output logic        tmo_err
);

  localparam logic [2:0]  STARVE_LIM_W = 3'(STARVE_LIM);
  localparam logic [11:0] TMO_CYC_W    = 12'(TMO_CYC);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_CMPLT, RESULT} state_t;

  state_t      state;
  logic        pend0, pend1;
  logic [2:0]  chnl0, chnl1;
  logic        owner;
  logic [2:0]  starve_cnt;
  logic [11:0] timer;
  logic        serv0, serv1, grant1;

  // A port counts as in service only while it holds the converter; a new
  // request during its RESULT cycle is accepted so it can re-queue at once.
  assign serv0  = (state == LAUNCH || state == WAIT_CMPLT) && !owner;
  assign serv1  = (state == LAUNCH || state == WAIT_CMPLT) && owner;
  assign grant1 = pend1 && (!pend0 || starve_cnt >= STARVE_LIM_W);
  assign busy   = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      pend0        <= 1'b0;
      pend1        <= 1'b0;
      chnl0        <= 3'd0;
      chnl1        <= 3'd0;
      owner        <= 1'b0;
      starve_cnt   <= 3'd0;
      timer        <= 12'd0;
      a2d_chnnl    <= 3'd0;
      a2d_strt_cnv <= 1'b0;
      req0_cmplt   <= 1'b0;
      req1_cmplt   <= 1'b0;
      req0_res     <= 12'd0;
      req1_res     <= 12'd0;
      ovr_err      <= 1'b0;
      tmo_err      <= 1'b0;
    end else begin
      a2d_strt_cnv <= 1'b0;
      req0_cmplt   <= 1'b0;
      req1_cmplt   <= 1'b0;

      if (req0_strt) begin
        if (pend0 || serv0) begin
          ovr_err <= 1'b1;
        end else begin
          pend0 <= 1'b1;
          chnl0 <= req0_chnnl;
        end
      end
      if (req1_strt) begin
        if (pend1 || serv1) begin
          ovr_err <= 1'b1;
        end else begin
          pend1 <= 1'b1;
          chnl1 <= req1_chnnl;
        end
      end

      if (!pend1) starve_cnt <= 3'd0;

      case (state)
        IDLE: begin
          if (pend0 || pend1) begin
            state        <= LAUNCH;
            a2d_strt_cnv <= 1'b1;
            if (grant1) begin
              owner      <= 1'b1;
              a2d_chnnl  <= chnl1;
              pend1      <= 1'b0;
              starve_cnt <= 3'd0;
            end else begin
              owner     <= 1'b0;
              a2d_chnnl <= chnl0;
              pend0     <= 1'b0;
              if (pend1 && starve_cnt != 3'd7) starve_cnt <= starve_cnt + 3'd1;
            end
          end
        end
        LAUNCH: begin
          timer <= 12'd0;
          state <= WAIT_CMPLT;
        end
        WAIT_CMPLT: begin
          // Real data beats the timeout when both land on the same cycle.
          if (a2d_cnv_cmplt) begin
            if (owner) begin
              req1_res   <= a2d_res;
              req1_cmplt <= 1'b1;
            end else begin
              req0_res   <= a2d_res;
              req0_cmplt <= 1'b1;
            end
            state <= RESULT;
          end else if (timer == TMO_CYC_W) begin
            if (owner) begin
              req1_res   <= 12'd0;
              req1_cmplt <= 1'b1;
            end else begin
              req0_res   <= 12'd0;
              req0_cmplt <= 1'b1;
            end
            tmo_err <= 1'b1;
            state   <= RESULT;
          end else begin
            timer <= timer + 12'd1;
          end
        end
        RESULT: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
